// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester arbitrated adder.
// Holds the FSM state encoding and the width of the shared adder.
package adder_arbiter_pkg;

    localparam int ADDER_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/adder_arbiter_carry_increment_adder.sv
// Carry-increment adder built from 4-bit blocks with a carry-in of zero.
// Each block adds its operands locally, then increments that result by the carry from the block below.
module carry_increment_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         of
);

    localparam int BLKS = N / 4;

    logic [4:0] blk_s [BLKS];
    logic [4:0] inc_s [BLKS];
    logic       carry_s [BLKS+1];

    assign carry_s[0] = 1'b0;

    // A local block sum is at most 5'd30, so the increment never wraps past bit 4.
    for (genvar i = 0; i < BLKS; i++) begin : g_blk
        assign blk_s[i]        = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
        assign inc_s[i]        = blk_s[i] + {4'd0, carry_s[i]};
        assign sum[4*i +: 4]   = inc_s[i][3:0];
        assign carry_s[i+1]    = inc_s[i][4];
    end

    assign cout = carry_s[BLKS];
    assign of   = cout ^ sum[N-1];

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder through a round-robin grant.
// Each operation runs IDLE -> CALC -> HOLD and holds its registered result until the consumer accepts it.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_in1,
    input  logic [N-1:0] req0_in2,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_in1,
    input  logic [N-1:0] req1_in2,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_of,
    output logic         busy
);

    state_e       state_q, state_d;
    logic         prio_q, prio_d;
    logic [N-1:0] op1_q, op1_d;
    logic [N-1:0] op2_q, op2_d;
    logic         id_q, id_d;
    logic [N-1:0] sum_q, sum_d;
    logic         cout_q, cout_d;
    logic         of_q, of_d;
    logic         rid_q, rid_d;

    logic         grant_s;
    logic         grant_vld_s;
    logic [N-1:0] add_sum_s;
    logic         add_cout_s;
    logic         add_of_s;

    carry_increment_adder #(.N(ADDER_W)) u_adder (
        .a    (op1_q),
        .b    (op2_q),
        .sum  (add_sum_s),
        .cout (add_cout_s),
        .of   (add_of_s)
    );

    // Round-robin grant: a lone requester wins, a tie goes to prio.
    always_comb begin
        grant_vld_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_s = prio_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Next-state, capture and ready logic.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        id_d       = id_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        of_d       = of_q;
        rid_d      = rid_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Ready is masked by rst so nothing appears accepted in a reset cycle.
                if (grant_vld_s && !rst) begin
                    req0_ready = ~grant_s;
                    req1_ready = grant_s;
                    op1_d      = grant_s ? req1_in1 : req0_in1;
                    op2_d      = grant_s ? req1_in2 : req0_in2;
                    id_d       = grant_s;
                    prio_d     = ~grant_s;
                    state_d    = ST_CALC;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CALC: begin
                sum_d   = add_sum_s;
                cout_d  = add_cout_s;
                of_d    = add_of_s;
                rid_d   = id_q;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            op1_q   <= {N{1'b0}};
            op2_q   <= {N{1'b0}};
            id_q    <= 1'b0;
            sum_q   <= {N{1'b0}};
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            of_q    <= of_d;
            rid_q   <= rid_d;
        end
    end

    assign rsp_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_of    = of_q;
    assign rsp_id    = rid_q;

endmodule
